instr_issue: RTL
================

Name: instr_issue

Overview:
Upstream issue stage for Decode_And_Execute. It accepts one instruction at a time over a valid/ready handshake and reads a 4-entry x 4-bit register file. It drives rs/rt/sel into the execute block, captures its rd result and writes it back. It also supports a load-immediate form so benches can seed registers without a separate write port.

Parameters:
DATA_W, 4, operand/result width; must equal Decode_And_Execute width (4)
ADDR_W, 2, register address width; NREGS = 2**ADDR_W = 4
CNT_W, 8, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  instruction present
in_ready  out  1  stage can accept (high only in IDLE)
in_instr  in  10  {ld[9], op[8:6], rd[5:4], rs[3:2], rt[1:0]}
ex_rs  out  4  operand A to execute block
ex_rt  out  4  operand B to execute block
ex_sel  out  3  op select to execute block
ex_rd  in  4  combinational result from execute block
wb_valid  out  1  writeback occurring this cycle
wb_addr  out  2  destination register
wb_data  out  4  value being written
retired  out  CNT_W  count of completed instructions
dbg_addr  in  2  debug read address
dbg_data  out  4  regfile[dbg_addr], combinational

Behaviour:
- Clocking: one clock, clk; rst is synchronous, active-high.
- Reset: state=IDLE, all regfile entries=0, in_ready=1 (registered from state), ex_rs/ex_rt/ex_sel=0, wb_valid=0, wb_addr=0, wb_data=0, retired=0.
- FSM states: IDLE, EXEC, WB.
- IDLE: in_ready=1. On edge with in_valid&in_ready:
  - latch the instruction fields;
  - latch opA=regfile[rs] and opB=regfile[rt], read in the same cycle;
  - go to EXEC.
  - in_valid low: stay in IDLE.
- EXEC: in_ready=0. ex_rs=opA, ex_rt=opB, ex_sel=op, held stable for the whole cycle.
  - At the edge, capture result: ld=1 gives imm={rs_field,rt_field}; ld=0 gives ex_rd.
  - Go to WB.
- WB: in_ready=0, wb_valid=1, wb_addr=rd, wb_data=captured result.
  - At the edge, regfile[rd]<=result, retired<=retired+1 (wraps 2**CNT_W-1 -> 0), then go to IDLE.
- ex_* outputs hold their last values outside EXEC. They are don't-care to the consumer but must not be X after reset.
- Latency and throughput:
  - Accept at edge E0; wb_valid is high in the cycle between E1 and E2.
  - The regfile is updated at E2, and the next accept is possible at E3.
  - Throughput is 1 instruction per 3 cycles.
- Hazards: none. The next instruction is read in IDLE, after the previous writeback has committed, so back-to-back dependent instructions see updated values.
- in_valid asserted while in_ready=0 is ignored. The upstream must hold the instruction until accepted.
- Same register for rs, rt and rd is legal: both operands read the old value, then rd is overwritten.
- Load (ld=1): op is still driven on ex_sel but ex_rd is ignored.
- dbg_data is combinational from the regfile and shows the new value from the cycle after E2.
- rst mid-operation (EXEC or WB): abort with no writeback, retired not incremented, and all reset values apply at that edge.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, WB=2'd2);
  - op constants: SUB=0, ADD=1, OR=2, AND=3, SRA_RT=4, ROL_RS=5, LT=6, EQ=7;
  - instruction field bit positions.
- One sub-module: regfile_4x4, with 2 combinational read ports (operand read shared with debug via separate port) and 1 synchronous write port cleared by rst.
- Bench top instantiates instr_issue wired to the real Decode_And_Execute.

Test Plan:
1. Reset held 2 cycles: retired=0, wb_valid=0, in_ready=1, dbg_data=0 for all 4 addresses.
2. LD r1,0x5 then LD r2,0x3 (in_instr=10'b1_000_01_01_01, 10'b1_000_10_00_11): each wb_valid pulses once, 2 cycles after accept; dbg r1=5, r2=3; retired=2.
3. SUB r3=r1-r2 then ADD r0=r3+r1: wb_data=2, then 7. The second result proves the dependent read saw r3=2. Then SUB r0=r2-r1 gives 4'hE (wrap).
4. LT r3,r2,r1 gives wb_data=4'b1011; EQ r3,r1,r1 gives 4'b1111; ROL_RS with r1=5 gives 4'b1010; SRA_RT with rt=r3=4'hF gives 4'hF.
5. in_valid held high continuously with 3 queued instructions: in_ready low in EXEC/WB, accepts exactly 3 cycles apart, no instruction dropped or duplicated, retired increments by 3.
6. rst asserted during EXEC of ADD r2: r2 is not written (0 after reset), wb_valid never asserts, retired=0. Separately, 256 LDs wrap retired to 0.

Source files
------------

// File: rtl/instr_issue_pkg.sv
// Shared definitions for the instruction issue stage: FSM encoding, op select
// codes and the bit layout of the 10-bit instruction word.
package instr_issue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam logic [2:0] OP_SUB    = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_OR     = 3'd2;
  localparam logic [2:0] OP_AND    = 3'd3;
  localparam logic [2:0] OP_SRA_RT = 3'd4;
  localparam logic [2:0] OP_ROL_RS = 3'd5;
  localparam logic [2:0] OP_LT     = 3'd6;
  localparam logic [2:0] OP_EQ     = 3'd7;

  localparam int INSTR_W = 10;
  localparam int LD_BIT  = 9;
  localparam int OP_HI   = 8;
  localparam int OP_LO   = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 4;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 2;
  localparam int RT_HI   = 1;
  localparam int RT_LO   = 0;

endpackage

// File: rtl/regfile_4x4.sv
// Small register file: two operand read ports, one debug read port and one
// synchronous write port; all entries clear on rst.
module regfile_4x4 #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic        [ADDR_W-1:0] waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic        [ADDR_W-1:0] ra_addr,
  output logic signed [DATA_W-1:0] ra_data,
  input  logic        [ADDR_W-1:0] rb_addr,
  output logic signed [DATA_W-1:0] rb_data,
  input  logic        [ADDR_W-1:0] dbg_addr,
  output logic signed [DATA_W-1:0] dbg_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic signed [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/instr_issue.sv
// Issue stage: accepts one instruction per 3 cycles, reads operands, drives the
// execute block, then writes the captured result back to the register file.
module instr_issue
  import instr_issue_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic       [INSTR_W-1:0] in_instr,
  output logic signed [DATA_W-1:0] ex_rs,
  output logic signed [DATA_W-1:0] ex_rt,
  output logic               [2:0] ex_sel,
  input  logic signed [DATA_W-1:0] ex_rd,
  output logic                     wb_valid,
  output logic        [ADDR_W-1:0] wb_addr,
  output logic signed [DATA_W-1:0] wb_data,
  output logic         [CNT_W-1:0] retired,
  input  logic        [ADDR_W-1:0] dbg_addr,
  output logic signed [DATA_W-1:0] dbg_data
);

  state_t state;

  logic                     ld_p0;
  logic               [2:0] op_p0;
  logic        [ADDR_W-1:0] rd_p0, rs_p0, rt_p0;
  logic signed [DATA_W-1:0] rf_a, rf_b;
  logic                     accept;

  logic                     ld_p1;
  logic        [ADDR_W-1:0] rd_p1;
  logic signed [DATA_W-1:0] imm_p1;

  assign ld_p0  = in_instr[LD_BIT];
  assign op_p0  = in_instr[OP_HI:OP_LO];
  assign rd_p0  = in_instr[RD_HI:RD_LO];
  assign rs_p0  = in_instr[RS_HI:RS_LO];
  assign rt_p0  = in_instr[RT_HI:RT_LO];
  assign accept = in_valid && in_ready;

  // Writeback uses the registered wb_* outputs directly, so the commit lands
  // on the edge that ends the WB cycle.
  regfile_4x4 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (wb_valid),
    .waddr    (wb_addr),
    .wdata    (wb_data),
    .ra_addr  (rs_p0),
    .ra_data  (rf_a),
    .rb_addr  (rt_p0),
    .rb_data  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // p0 -> p1: decode fields needed later, held until the next accept
  always_ff @(posedge clk) begin
    if (accept) begin
      ld_p1  <= ld_p0;
      rd_p1  <= rd_p0;
      imm_p1 <= {rs_p0, rt_p0};
    end
  end

  // Control FSM; the ex_* registers double as the latched operands
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b1;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_sel   <= '0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      retired  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= EXEC;
            in_ready <= 1'b0;
            ex_rs    <= rf_a;
            ex_rt    <= rf_b;
            ex_sel   <= op_p0;
          end
        end
        EXEC: begin
          state    <= WB;
          wb_valid <= 1'b1;
          wb_addr  <= rd_p1;
          wb_data  <= ld_p1 ? imm_p1 : ex_rd;
        end
        WB: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
          in_ready <= 1'b1;
          retired  <= retired + 1'b1;
        end
        default: begin
          state    <= IDLE;
          wb_valid <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
